// File: rtl/acc_responder_if.sv
// ACC_BUS request/response bundle seen from the accelerator side.
// Signal names keep the responder's point of view: *_i are driven by the
// initiator (master), *_o are driven by the responder (slave).
//   Q channel: q_addr_i, q_data_op_i, q_data_arg{a,b,c}_i, q_id_i,
//              q_valid_i (in), q_ready_o (out)
//   P channel: p_data0_o, p_data1_o, p_dual_writeback_o, p_id_o, p_rd_o,
//              p_error_o, p_valid_o (out), p_ready_i (in)
interface acc_responder_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned IdWidth   = 4
);
  logic [AddrWidth-1:0] q_addr_i;
  logic [31:0]          q_data_op_i;
  logic [DataWidth-1:0] q_data_arga_i;
  logic [DataWidth-1:0] q_data_argb_i;
  logic [DataWidth-1:0] q_data_argc_i;
  logic [IdWidth-1:0]   q_id_i;
  logic                 q_valid_i;
  logic                 q_ready_o;

  logic [DataWidth-1:0] p_data0_o;
  logic [DataWidth-1:0] p_data1_o;
  logic                 p_dual_writeback_o;
  logic [IdWidth-1:0]   p_id_o;
  logic [4:0]           p_rd_o;
  logic                 p_error_o;
  logic                 p_valid_o;
  logic                 p_ready_i;

  modport master (
    output q_addr_i, q_data_op_i, q_data_arga_i, q_data_argb_i, q_data_argc_i,
           q_id_i, q_valid_i, p_ready_i,
    input  q_ready_o, p_data0_o, p_data1_o, p_dual_writeback_o, p_id_o,
           p_rd_o, p_error_o, p_valid_o
  );

  modport slave (
    input  q_addr_i, q_data_op_i, q_data_arga_i, q_data_argb_i, q_data_argc_i,
           q_id_i, q_valid_i, p_ready_i,
    output q_ready_o, p_data0_o, p_data1_o, p_dual_writeback_o, p_id_o,
           p_rd_o, p_error_o, p_valid_o
  );
endinterface

// File: rtl/acc_responder.sv
// acc_responder: accelerator endpoint of ACC_BUS.
// Accepts offloaded instructions on Q, computes a small integer result at
// acceptance time, holds it in an in-order buffer of Depth entries and
// releases it on P once Latency cycles have elapsed since the handshake.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset (drops all pending entries)
//   bus    - acc_responder_if.slave carrying the Q and P channels
module acc_responder #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned Depth     = 4,
  parameter int unsigned Latency   = 2,
  parameter int unsigned AccAddr   = 32'd0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  acc_responder_if.slave bus
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CdW  = (Latency > 1) ? $clog2(Latency) : 1;

  localparam logic [CntW-1:0]      CountFull = CntW'(Depth);
  localparam logic [PtrW-1:0]      PtrLast   = PtrW'(Depth - 1);
  localparam logic [CdW-1:0]       CdInit    = CdW'(Latency - 1);
  localparam logic [AddrWidth-1:0] OwnAddr   = AddrWidth'(AccAddr);

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    if (p == PtrLast) begin
      return '0;
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  // Buffer storage
  logic [DataWidth-1:0] r_data0 [Depth];
  logic [DataWidth-1:0] r_data1 [Depth];
  logic                 r_dual  [Depth];
  logic                 r_err   [Depth];
  logic [IdWidth-1:0]   r_id    [Depth];
  logic [4:0]           r_rd    [Depth];
  logic [CdW-1:0]       r_cd    [Depth];

  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;

  logic                 w_not_full;
  logic                 w_head_valid;
  logic                 w_push;
  logic                 w_pop;
  logic [2:0]           w_funct3;
  logic [DataWidth-1:0] w_op_data0;
  logic [DataWidth-1:0] w_op_data1;
  logic                 w_op_dual;
  logic                 w_op_err;
  logic                 w_unused_op;

  // Only rd and funct3 are decoded; the rest of the instruction is ignored.
  assign w_unused_op = ^{bus.q_data_op_i[31:15], bus.q_data_op_i[6:0]};
  assign w_funct3    = bus.q_data_op_i[14:12];

  // Ready and valid come from registered state only, never from inputs.
  assign w_not_full   = (r_count != CountFull);
  assign w_head_valid = (r_count != '0) && (r_cd[r_rptr] == '0);
  assign w_push       = bus.q_valid_i && w_not_full;
  assign w_pop        = w_head_valid && bus.p_ready_i;

  assign bus.q_ready_o = w_not_full;

  // Result computation for the request currently on Q.
  always_comb begin
    w_op_data0 = '0;
    w_op_data1 = '0;
    w_op_dual  = 1'b0;
    w_op_err   = 1'b0;
    if (bus.q_addr_i != OwnAddr) begin
      w_op_err = 1'b1;
    end else begin
      case (w_funct3)
        3'b000: w_op_data0 = bus.q_data_arga_i + bus.q_data_argb_i;
        3'b001: w_op_data0 = bus.q_data_arga_i ^ bus.q_data_argb_i;
        3'b010: w_op_data0 = bus.q_data_arga_i & bus.q_data_argb_i;
        3'b011: w_op_data0 = bus.q_data_arga_i + bus.q_data_argb_i + bus.q_data_argc_i;
        3'b100: begin
          w_op_data0 = bus.q_data_arga_i;
          w_op_data1 = bus.q_data_argb_i;
          w_op_dual  = 1'b1;
        end
        default: w_op_err = 1'b1;
      endcase
    end
  end

  // Buffer storage, pointers, occupancy and per-entry latency countdown.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        r_data0[i] <= '0;
        r_data1[i] <= '0;
        r_dual[i]  <= 1'b0;
        r_err[i]   <= 1'b0;
        r_id[i]    <= '0;
        r_rd[i]    <= '0;
        r_cd[i]    <= '0;
      end
    end else begin
      // Countdowns run regardless of P-side stalls.
      for (int unsigned i = 0; i < Depth; i++) begin
        if (r_cd[i] != '0) begin
          r_cd[i] <= r_cd[i] - CdW'(1);
        end
      end
      if (w_push) begin
        r_data0[r_wptr] <= w_op_data0;
        r_data1[r_wptr] <= w_op_data1;
        r_dual[r_wptr]  <= w_op_dual;
        r_err[r_wptr]   <= w_op_err;
        r_id[r_wptr]    <= bus.q_id_i;
        r_rd[r_wptr]    <= bus.q_data_op_i[11:7];
        r_cd[r_wptr]    <= CdInit;
        r_wptr          <= ptr_next(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_next(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // P channel presents the head entry, forced to zero while not valid.
  always_comb begin
    bus.p_valid_o          = 1'b0;
    bus.p_data0_o          = '0;
    bus.p_data1_o          = '0;
    bus.p_dual_writeback_o = 1'b0;
    bus.p_id_o             = '0;
    bus.p_rd_o             = '0;
    bus.p_error_o          = 1'b0;
    if (w_head_valid) begin
      bus.p_valid_o          = 1'b1;
      bus.p_data0_o          = r_data0[r_rptr];
      bus.p_data1_o          = r_data1[r_rptr];
      bus.p_dual_writeback_o = r_dual[r_rptr];
      bus.p_id_o             = r_id[r_rptr];
      bus.p_rd_o             = r_rd[r_rptr];
      bus.p_error_o          = r_err[r_rptr];
    end else begin
      bus.p_valid_o = 1'b0;
    end
  end

  // Full buffer must never advertise space.
  a_no_ready_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_count == CountFull) |-> !bus.q_ready_o);

  // A stalled response must hold every P field until it is taken.
  a_p_stable_on_stall : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.p_valid_o && !bus.p_ready_i) |=>
      (bus.p_valid_o && $stable({bus.p_data0_o, bus.p_data1_o, bus.p_dual_writeback_o,
                                 bus.p_id_o, bus.p_rd_o, bus.p_error_o})));

endmodule

// File: tb/tb_acc_responder.sv
module tb_acc_responder;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int IW = 4;
  localparam int DEPTH = 4;
  localparam int LAT = 2;
  localparam int ACC = 0;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        dual;
    logic        err;
    logic [3:0]  id;
    logic [4:0]  rd;
    int          t;
  } resp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  resp_t mq[$];
  logic [3:0] popped[$];

  acc_responder_if #(.DataWidth(DW), .AddrWidth(AW), .IdWidth(IW)) bus ();

  acc_responder #(
    .DataWidth(DW), .AddrWidth(AW), .IdWidth(IW),
    .Depth(DEPTH), .Latency(LAT), .AccAddr(ACC)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_op(input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, 7'b0001011};
  endfunction

  // Reference: result of a request, derived from the operation table.
  function automatic resp_t predict(input logic [3:0] addr, input logic [31:0] op,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] c, input logic [3:0] id, input int t);
    resp_t r;
    logic [2:0] f;
    f = op[14:12];
    r.rd = op[11:7]; r.id = id; r.t = t;
    r.d0 = 32'd0; r.d1 = 32'd0; r.dual = 1'b0; r.err = 1'b0;
    if (int'(addr) != ACC) r.err = 1'b1;
    else if (f == 3'd0) r.d0 = a + b;
    else if (f == 3'd1) r.d0 = a ^ b;
    else if (f == 3'd2) r.d0 = a & b;
    else if (f == 3'd3) r.d0 = a + b + c;
    else if (f == 3'd4) begin r.d0 = a; r.d1 = b; r.dual = 1'b1; end
    else r.err = 1'b1;
    return r;
  endfunction

  task automatic set_req(input logic [3:0] addr, input logic [31:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic [3:0] id);
    bus.q_valid_i = 1'b1; bus.q_addr_i = addr; bus.q_data_op_i = op;
    bus.q_data_arga_i = a; bus.q_data_argb_i = b; bus.q_data_argc_i = c; bus.q_id_i = id;
  endtask

  task automatic idle_q();
    bus.q_valid_i = 1'b0; bus.q_addr_i = 4'd0; bus.q_data_op_i = 32'd0;
    bus.q_data_arga_i = 32'd0; bus.q_data_argb_i = 32'd0; bus.q_data_argc_i = 32'd0;
    bus.q_id_i = 4'd0;
  endtask

  // One clock cycle: compare DUT against the model, then advance both.
  task automatic tick();
    logic mr, mv, hq, hp;
    resp_t h, nw;
    mr = (mq.size() != DEPTH);
    mv = (mq.size() > 0) && (cyc >= mq[0].t + LAT);
    check("q_ready", 64'(bus.q_ready_o), 64'(mr));
    check("p_valid", 64'(bus.p_valid_o), 64'(mv));
    if (mv) begin
      h = mq[0];
      check("p_data0", 64'(bus.p_data0_o), 64'(h.d0));
      check("p_data1", 64'(bus.p_data1_o), 64'(h.d1));
      check("p_flags", 64'({bus.p_dual_writeback_o, bus.p_error_o, bus.p_rd_o, bus.p_id_o}),
            64'({h.dual, h.err, h.rd, h.id}));
    end else begin
      check("p_idle_zero", 64'({bus.p_data0_o, bus.p_dual_writeback_o, bus.p_error_o,
                                bus.p_rd_o, bus.p_id_o}) | 64'(bus.p_data1_o), 64'd0);
    end
    hq = bus.q_valid_i && mr;
    hp = mv && bus.p_ready_i;
    if (hq) nw = predict(bus.q_addr_i, bus.q_data_op_i, bus.q_data_arga_i,
                         bus.q_data_argb_i, bus.q_data_argc_i, bus.q_id_i, cyc);
    if (hp) popped.push_back(bus.p_id_o);
    @(posedge clk);
    if (hp) void'(mq.pop_front());
    if (hq) mq.push_back(nw);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    idle_q();
    bus.p_ready_i = 1'b1;
    for (int k = 0; k < 60 && mq.size() > 0; k++) tick();
    check(tag, 64'(mq.size()), 64'd0);
    tick();
  endtask

  initial begin
    logic acc;
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0;
    idle_q();
    bus.p_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_q_ready", 64'(bus.q_ready_o), 64'd1);
    check("rst_p_valid", 64'(bus.p_valid_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single add: accepted cycle c, visible exactly at c+2 for one cycle.
    bus.p_ready_i = 1'b1;
    set_req(4'd0, mk_op(3'b000, 5'd5), 32'd3, 32'd4, 32'd0, 4'd2);
    tick();
    idle_q();
    tick();
    check("add_valid", 64'(bus.p_valid_o), 64'd1);
    check("add_data0", 64'(bus.p_data0_o), 64'd7);
    check("add_rd", 64'(bus.p_rd_o), 64'd5);
    check("add_id", 64'(bus.p_id_o), 64'd2);
    check("add_err", 64'(bus.p_error_o), 64'd0);
    tick();
    check("add_one_wide", 64'(bus.p_valid_o), 64'd0);
    drain("add_drain");

    // Backpressure: six requests against a stalled P channel.
    popped.delete();
    bus.p_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_req(4'd0, mk_op(3'b001, 5'(i + 1)), $urandom, $urandom, 32'd0, 4'(i));
      if (i == 4) check("bp_full_ready", 64'(bus.q_ready_o), 64'd0);
      tick();
    end
    idle_q();
    repeat (3) tick();
    bus.p_ready_i = 1'b1;
    for (int i = 4; i < 6; i++) begin
      set_req(4'd0, mk_op(3'b010, 5'(i + 1)), $urandom, $urandom, 32'd0, 4'(i));
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
        acc = (mq.size() != DEPTH);
        tick();
      end
      check("bp_retry_accept", 64'(acc), 64'd1);
    end
    drain("bp_drain");
    check("bp_count", 64'(popped.size()), 64'd6);
    for (int i = 0; i < 6 && i < popped.size(); i++) check("bp_order", 64'(popped[i]), 64'(i));

    // Dual writeback then three-operand wrap.
    bus.p_ready_i = 1'b0;
    set_req(4'd0, mk_op(3'b100, 5'd10), 32'hAAAA_AAAA, 32'h5555_5555, 32'd0, 4'd7);
    tick();
    set_req(4'd0, mk_op(3'b011, 5'd11), 32'hFFFF_FFFF, 32'd1, 32'd1, 4'd8);
    tick();
    idle_q();
    check("dual_d0", 64'(bus.p_data0_o), 64'hAAAA_AAAA);
    check("dual_d1", 64'(bus.p_data1_o), 64'h5555_5555);
    check("dual_flag", 64'(bus.p_dual_writeback_o), 64'd1);
    bus.p_ready_i = 1'b1;
    tick();
    check("wrap_d0", 64'(bus.p_data0_o), 64'd1);
    check("wrap_dual", 64'({bus.p_dual_writeback_o, bus.p_data1_o}), 64'd0);
    drain("dual_drain");

    // Errors: bad funct3 and foreign address.
    bus.p_ready_i = 1'b0;
    set_req(4'd0, mk_op(3'b111, 5'd3), 32'd9, 32'd9, 32'd0, 4'd9);
    tick();
    set_req(4'(ACC + 1), mk_op(3'b000, 5'd4), 32'd1, 32'd2, 32'd0, 4'd10);
    tick();
    idle_q();
    check("err_f3", 64'({bus.p_error_o, bus.p_id_o, bus.p_data0_o}), {27'd0, 1'b1, 4'd9, 32'd0});
    bus.p_ready_i = 1'b1;
    tick();
    check("err_addr", 64'({bus.p_error_o, bus.p_id_o, bus.p_data0_o}), {27'd0, 1'b1, 4'd10, 32'd0});
    drain("err_drain");

    // Full with pop and push requested in the same cycle.
    popped.delete();
    bus.p_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(4'd0, mk_op(3'b000, 5'd1), $urandom, $urandom, 32'd0, 4'(i));
      tick();
    end
    set_req(4'd0, mk_op(3'b000, 5'd2), 32'd5, 32'd6, 32'd0, 4'd11);
    bus.p_ready_i = 1'b1;
    check("full_no_ready", 64'(bus.q_ready_o), 64'd0);
    check("full_head_valid", 64'(bus.p_valid_o), 64'd1);
    tick();
    check("full_ready_after_pop", 64'(bus.q_ready_o), 64'd1);
    tick();
    drain("full_drain");
    check("full_count", 64'(popped.size()), 64'd5);
    if (popped.size() == 5) begin
      for (int i = 0; i < 4; i++) check("full_order", 64'(popped[i]), 64'(i));
      check("full_last", 64'(popped[4]), 64'd11);
    end

    // Reset in the middle of a cycle with three pending entries.
    bus.p_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(4'd0, mk_op(3'b000, 5'd7), $urandom, $urandom, 32'd0, 4'(i + 1));
      tick();
    end
    idle_q();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_p_valid", 64'(bus.p_valid_o), 64'd0);
    check("midrst_q_ready", 64'(bus.q_ready_o), 64'd1);
    check("midrst_data0", 64'(bus.p_data0_o), 64'd0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.p_ready_i = 1'b1;
    repeat (4) tick();
    set_req(4'd0, mk_op(3'b000, 5'd6), 32'd20, 32'd22, 32'd0, 4'd12);
    tick();
    idle_q();
    tick();
    check("post_rst_resp", 64'({bus.p_valid_o, bus.p_id_o, bus.p_data0_o}), {27'd0, 1'b1, 4'd12, 32'd42});
    drain("post_rst_drain");

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) != 0)
        set_req(($urandom_range(0, 7) == 0) ? 4'(ACC + 1) : 4'(ACC),
                mk_op(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))),
                $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)));
      else
        idle_q();
      bus.p_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/acc_responder.md
Name: acc_responder

Overview:
- Accelerator-side endpoint of the ACC_BUS request/response protocol.
- Accepts offloaded instructions on the Q channel and executes a small fixed-latency integer operation set.
- Returns results on the P channel in order, carrying the request ID.
- Serves as the reference accelerator shell and the bench-side responder for offloading initiators and interconnects.

Parameters:
DataWidth, 32, operand/result width
AddrWidth, 4, width of q_addr
IdWidth, 4, width of q_id/p_id
Depth, 4, pending-request buffer entries (>=1)
Latency, 2, cycles from Q handshake to earliest p_valid (>=1)
AccAddr, 0, address this responder answers; mismatching requests complete with error

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
q_addr_i  in  AddrWidth  target accelerator address
q_data_op_i  in  32  offloaded RISC-V instruction
q_data_arga_i  in  DataWidth  operand a (rs1)
q_data_argb_i  in  DataWidth  operand b (rs2)
q_data_argc_i  in  DataWidth  operand c (rs3)
q_id_i  in  IdWidth  request ID
q_valid_i  in  1  request valid
q_ready_o  out  1  request ready
p_data0_o  out  DataWidth  result for rd
p_data1_o  out  DataWidth  result for rd+1 (dual writeback)
p_dual_writeback_o  out  1  p_data1 valid
p_id_o  out  IdWidth  ID of the completed request
p_rd_o  out  5  destination register
p_error_o  out  1  request failed
p_valid_o  out  1  response valid
p_ready_i  in  1  response ready

Behaviour:
- Clock, reset: one clock clk_i; rst_ni is asynchronous and active-low.
- Reset state: buffer empty; q_ready_o=1; p_valid_o=0; all other P outputs 0. Whenever p_valid_o=0, P data/flags are 0.
- Accept: on q_valid_i && q_ready_o at a rising edge, push one entry holding the computed result, id, rd and a countdown initialised to Latency-1.
- Backpressure: q_ready_o = (count != Depth). It depends only on registered state, never on q_valid_i or p_ready_i. When full, there is no bypass, even if a pop happens in the same cycle.
- Countdown: each entry's countdown decrements every cycle while >0, independent of stalls.
- Response valid: p_valid_o = !empty && head.countdown==0. A request handshaken in cycle c gives p_valid_o no earlier than cycle c+Latency.
- Pop: on p_valid_o && p_ready_i. P outputs present the head entry and stay stable until the pop.
- Ordering: responses return strictly in acceptance order.
- Simultaneous push and pop in one cycle: count is unchanged, and the pushed entry goes behind the remaining ones.
- Decode:
  - rd = op[11:7]; funct3 = op[14:12].
  - 000: data0 = a+b (mod 2^DataWidth)
  - 001: data0 = a^b
  - 010: data0 = a&b
  - 011: data0 = (a+b)+c (mod 2^DataWidth)
  - 100: data0 = a, data1 = b, dual_writeback = 1
  - other funct3: error = 1, data0 = 0
- Address mismatch: if q_addr_i != AccAddr, error = 1 and data0 = 0 regardless of funct3. The request is still accepted and answered.
- data1 = 0 and dual_writeback = 0 except for funct3 100.
- Counter width: count is $clog2(Depth+1) bits. Read/write pointers wrap modulo Depth; non-power-of-two Depth must work.
- Reset mid-operation: all pending entries are discarded without responses. p_valid_o drops asynchronously.
- Undefined input: q inputs are ignored when q_valid_i=0.
- Assertions (simulation only):
  - q_ready_o never asserted while count==Depth.
  - P outputs stable while p_valid_o && !p_ready_i.

Test Plan:
- Single add: Latency=2. Send op funct3=000, rd=5, a=3, b=4, id=2 at cycle 0 with p_ready=1 -> p_valid at cycle 2 with data0=7, rd=5, id=2, error=0; one cycle wide.
- Backpressure: Depth=4, p_ready=0, 6 back-to-back requests with ids 0..5 -> 4 accepted, q_ready=0 from cycle 4. Raise p_ready -> ids 0,1,2,3 then 4,5 in order; P outputs stable during the stall.
- Dual writeback and wrap: funct3=100, a=0xAAAA_AAAA, b=0x5555_5555 -> data0=0xAAAAAAAA, data1=0x55555555, dual=1. Then funct3=011 with a=0xFFFF_FFFF, b=1, c=1 -> data0=1.
- Errors: funct3=111 -> error=1, data0=0. q_addr=AccAddr+1 with funct3=000 -> error=1. Both are still answered with their ids.
- Full with simultaneous events: buffer full and head valid, p_ready=1, q_valid=1 -> no push that cycle (q_ready=0). Next cycle q_ready=1 and push accepted; count stays correct.
- Reset mid-op: 3 pending entries, rst_ni low mid-cycle -> p_valid=0 immediately; after release q_ready=1, no stale responses; a new request returns normally.
